vga_frame_monitor: RTL and testbench

Synthesizable, parametrised monitor that sits on the output side of the VGA controller. It tracks the active-pixel raster position, streams each sampled pixel with its coordinates, and accumulates a per-frame checksum. It flags short lines and truncated frames. It gives on-chip and in-bench frame verification without dumping every pixel to a file.

---
 rtl/vga_frame_monitor_if.sv | 14 +
 rtl/vga_frame_monitor.sv | 163 ++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_monitor_if.sv
// rtl/vga_frame_monitor_if.sv - video bus from the VGA controller into the frame monitor
interface vga_frame_monitor_if #(
  parameter int COLOR_WIDTH = 4
) ();
  logic                   pixel_pulse;
  logic                   video_on;
  logic                   vsync;
  logic [COLOR_WIDTH-1:0] red;
  logic [COLOR_WIDTH-1:0] green;
  logic [COLOR_WIDTH-1:0] blue;

  modport master (output pixel_pulse, video_on, vsync, red, green, blue);
  modport slave  (input  pixel_pulse, video_on, vsync, red, green, blue);
endinterface

// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - raster tracker, pixel streamer and per-frame checksum for VGA output
module vga_frame_monitor #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int COLOR_WIDTH    = 4,
  parameter int CHECKSUM_WIDTH = 32,
  localparam int COL_W         = $clog2(H_ACTIVE),
  localparam int ROW_W         = $clog2(V_ACTIVE),
  localparam int PIX_W         = 3 * COLOR_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  vga_frame_monitor_if.slave        vid,
  input  logic                      clear_errors_i,
  output logic                      pixel_valid_o,
  output logic [PIX_W-1:0]          pixel_data_o,
  output logic [COL_W-1:0]          col_o,
  output logic [ROW_W-1:0]          row_o,
  output logic                      frame_done_o,
  output logic [CHECKSUM_WIDTH-1:0] frame_checksum_o,
  output logic [15:0]               frame_count_o,
  output logic                      line_error_o,
  output logic                      frame_error_o
);

  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [CHECKSUM_WIDTH-1:0] sum_q, sum_d;
  logic                      video_on_q, video_on_d;
  logic                      vsync_q, vsync_d;
  logic                      pixel_valid_q, pixel_valid_d;
  logic [PIX_W-1:0]          pixel_data_q, pixel_data_d;
  logic [COL_W-1:0]          col_out_q, col_out_d;
  logic [ROW_W-1:0]          row_out_q, row_out_d;
  logic                      frame_done_q, frame_done_d;
  logic [CHECKSUM_WIDTH-1:0] checksum_q, checksum_d;
  logic [15:0]               count_q, count_d;
  logic                      line_err_q, line_err_d;
  logic                      frame_err_q, frame_err_d;

  logic                      sample;
  logic                      vsync_fall;
  logic                      line_fall;
  logic                      short_evt;
  logic                      trunc_evt;
  logic                      last_col;
  logic                      last_row;
  logic [PIX_W-1:0]          pix;
  logic [CHECKSUM_WIDTH-1:0] sum_next;

  assign pix        = {vid.red, vid.green, vid.blue};
  assign sample     = enable_i & vid.pixel_pulse & vid.video_on;
  assign vsync_fall = vsync_q & ~vid.vsync;
  assign line_fall  = video_on_q & ~vid.video_on;
  assign last_col   = (col_q == COL_W'(H_ACTIVE - 1));
  assign last_row   = (row_q == ROW_W'(V_ACTIVE - 1));
  // Truncation is judged on the position before any same-cycle sample.
  assign trunc_evt  = enable_i & vsync_fall & ((row_q != '0) | (col_q != '0));
  assign short_evt  = enable_i & line_fall & (col_q != '0);
  assign sum_next   = sum_q + CHECKSUM_WIDTH'(pix);

  // Next-state: raster position, checksum, output capture and sticky flags.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    sum_d         = sum_q;
    pixel_valid_d = 1'b0;
    pixel_data_d  = pixel_data_q;
    col_out_d     = col_out_q;
    row_out_d     = row_out_q;
    frame_done_d  = 1'b0;
    checksum_d    = checksum_q;
    count_d       = count_q;
    video_on_d    = vid.video_on;
    vsync_d       = vid.vsync;

    if (!enable_i || vsync_fall) begin
      // Disabled, or a new frame is starting: any same-cycle sample is dropped.
      col_d = '0;
      row_d = '0;
      sum_d = '0;
    end else if (short_evt) begin
      col_d = '0;
      row_d = last_row ? '0 : row_q + ROW_W'(1);
    end else if (sample) begin
      pixel_valid_d = 1'b1;
      pixel_data_d  = pix;
      col_out_d     = col_q;
      row_out_d     = row_q;
      sum_d         = sum_next;
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d        = '0;
          sum_d        = '0;
          checksum_d   = sum_next;
          count_d      = count_q + 16'd1;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    // A fresh error beats a simultaneous clear.
    if (short_evt)           line_err_d = 1'b1;
    else if (clear_errors_i) line_err_d = 1'b0;
    else                     line_err_d = line_err_q;

    if (trunc_evt)           frame_err_d = 1'b1;
    else if (clear_errors_i) frame_err_d = 1'b0;
    else                     frame_err_d = frame_err_q;
  end

  // State registers; vsync_q resets high so the first cycle sees no false edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q         <= '0;
      row_q         <= '0;
      sum_q         <= '0;
      video_on_q    <= 1'b0;
      vsync_q       <= 1'b1;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= '0;
      col_out_q     <= '0;
      row_out_q     <= '0;
      frame_done_q  <= 1'b0;
      checksum_q    <= '0;
      count_q       <= '0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      sum_q         <= sum_d;
      video_on_q    <= video_on_d;
      vsync_q       <= vsync_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= pixel_data_d;
      col_out_q     <= col_out_d;
      row_out_q     <= row_out_d;
      frame_done_q  <= frame_done_d;
      checksum_q    <= checksum_d;
      count_q       <= count_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign pixel_valid_o    = pixel_valid_q;
  assign pixel_data_o     = pixel_data_q;
  assign col_o            = col_out_q;
  assign row_o            = row_out_q;
  assign frame_done_o     = frame_done_q;
  assign frame_checksum_o = checksum_q;
  assign frame_count_o    = count_q;
  assign line_error_o     = line_err_q;
  assign frame_error_o    = frame_err_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb/tb_vga_frame_monitor.sv - scoreboard bench for vga_frame_monitor on an 8x4 raster
module tb_vga_frame_monitor;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int CW  = 4;
  localparam int CKW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic        pixel_valid;
  logic [11:0] pixel_data;
  logic [2:0]  col;
  logic [1:0]  row;
  logic        frame_done;
  logic [31:0] frame_checksum;
  logic [15:0] frame_count;
  logic        line_error;
  logic        frame_error;

  vga_frame_monitor_if #(.COLOR_WIDTH(CW)) vid ();

  vga_frame_monitor #(
    .H_ACTIVE(H), .V_ACTIVE(V), .COLOR_WIDTH(CW), .CHECKSUM_WIDTH(CKW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .vid(vid), .clear_errors_i(clr),
    .pixel_valid_o(pixel_valid), .pixel_data_o(pixel_data), .col_o(col), .row_o(row),
    .frame_done_o(frame_done), .frame_checksum_o(frame_checksum), .frame_count_o(frame_count),
    .line_error_o(line_error), .frame_error_o(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        pos_chk;
    logic [11:0] data;
    logic [2:0]  col;
    logic [1:0]  row;
    logic        done;
    logic [31:0] chk;
    logic [15:0] cnt;
    logic        lerr;
    logic        ferr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   n_checks = 0;
  int   n_errors = 0;

  int          m_col, m_row;
  logic [31:0] m_sum, m_chk;
  logic [15:0] m_cnt;
  logic        m_lerr, m_ferr, m_von_q, m_vs_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the expected post-edge outputs.
  task automatic step(input logic r, input logic e, input logic pp, input logic von,
                      input logic vs, input logic clr_in, input logic [11:0] pix);
    exp_t x;
    logic vf, lf, ev_f, ev_l;
    @(negedge clk);
    rst = r; en = e; clr = clr_in;
    vid.pixel_pulse = pp; vid.video_on = von; vid.vsync = vs;
    {vid.red, vid.green, vid.blue} = pix;
    x = '0;
    if (r) begin
      m_col = 0; m_row = 0; m_sum = '0; m_chk = '0; m_cnt = '0;
      m_lerr = 1'b0; m_ferr = 1'b0; m_von_q = 1'b0; m_vs_q = 1'b1;
      x.pos_chk = 1'b1;
    end else begin
      vf   = m_vs_q & ~vs;
      lf   = m_von_q & ~von;
      ev_f = e & vf & !(m_row == 0 && m_col == 0);
      ev_l = e & lf & (m_col != 0);
      if (!e || vf) begin
        m_col = 0; m_row = 0; m_sum = '0;
      end else if (ev_l) begin
        m_col = 0;
        m_row = (m_row == V - 1) ? 0 : m_row + 1;
      end else if (pp && von) begin
        x.valid = 1'b1; x.pos_chk = 1'b1; x.data = pix;
        x.col = 3'(m_col); x.row = 2'(m_row);
        m_sum = m_sum + 32'(pix);
        if (m_col == H - 1 && m_row == V - 1) begin
          m_chk = m_sum; m_cnt = m_cnt + 16'd1; x.done = 1'b1;
          m_col = 0; m_row = 0; m_sum = '0;
        end else if (m_col == H - 1) begin
          m_col = 0; m_row = m_row + 1;
        end else begin
          m_col = m_col + 1;
        end
      end
      if (ev_f) m_ferr = 1'b1; else if (clr_in) m_ferr = 1'b0;
      if (ev_l) m_lerr = 1'b1; else if (clr_in) m_lerr = 1'b0;
      m_von_q = von; m_vs_q = vs;
    end
    x.chk = m_chk; x.cnt = m_cnt; x.lerr = m_lerr; x.ferr = m_ferr;
    sb.push_back(x);
  endtask

  function automatic logic [11:0] next_pix(input bit rnd);
    if (rnd) return 12'($urandom);
    return 12'(m_col + 16 * m_row);
  endfunction

  task automatic idle(input int n, input logic clr_in);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, clr_in, 12'h0);
  endtask

  // n samples on the current line; pulse every other cycle unless b2b.
  task automatic samples(input int n, input bit rnd, input bit b2b);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, next_pix(rnd));
      if (!b2b) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h0);
    end
  endtask

  task automatic line(input int n, input bit rnd, input bit b2b);
    samples(n, rnd, b2b);
    idle(2, 1'b0);
  endtask

  task automatic vsync_pulse();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0);
  endtask

  task automatic frame(input bit rnd, input bit b2b);
    for (int r = 0; r < V; r++) line(H, rnd, b2b);
    vsync_pulse();
  endtask

  // Scoreboard: one expected entry per driven cycle, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_x = sb.pop_front();
      check_eq("pixel_valid", 32'(pixel_valid), 32'(mon_x.valid));
      if (mon_x.pos_chk) begin
        check_eq("pixel_data", 32'(pixel_data), 32'(mon_x.data));
        check_eq("col", 32'(col), 32'(mon_x.col));
        check_eq("row", 32'(row), 32'(mon_x.row));
      end
      check_eq("frame_done", 32'(frame_done), 32'(mon_x.done));
      check_eq("frame_checksum", frame_checksum, mon_x.chk);
      check_eq("frame_count", 32'(frame_count), 32'(mon_x.cnt));
      check_eq("line_error", 32'(line_error), 32'(mon_x.lerr));
      check_eq("frame_error", 32'(frame_error), 32'(mon_x.ferr));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    vid.pixel_pulse = 1'b0; vid.video_on = 1'b0; vid.vsync = 1'b1;
    vid.red = '0; vid.green = '0; vid.blue = '0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0);

    // Coordinate-pattern frame: sum of col+16*row over 8x4 is 880.
    frame(1'b0, 1'b0);
    idle(2, 1'b0);
    check_eq("coord_checksum", frame_checksum, 32'd880);
    check_eq("coord_count", 32'(frame_count), 32'd1);

    // Random pixels, one sample every cycle.
    frame(1'b1, 1'b1);
    idle(2, 1'b0);
    check_eq("b2b_count", 32'(frame_count), 32'd2);

    // Short line on row 1, next sample must land on (0,2).
    line(H, 1'b0, 1'b0);
    samples(5, 1'b0, 1'b0);
    idle(2, 1'b0);
    check_eq("short_flag", 32'(line_error), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'hABC);
    @(posedge clk); #2;
    check_eq("short_next_col", 32'(col), 32'd0);
    check_eq("short_next_row", 32'(row), 32'd2);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h0);
    line(H - 1, 1'b0, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    check_eq("short_cleared", 32'(line_error), 32'd0);
    line(H, 1'b0, 1'b0);
    vsync_pulse();

    // Truncated frame at row 2, col 3.
    line(H, 1'b0, 1'b0);
    line(H, 1'b0, 1'b0);
    samples(3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0);
    check_eq("trunc_flag", 32'(frame_error), 32'd1);
    check_eq("trunc_count", 32'(frame_count), 32'd3);
    frame(1'b0, 1'b0);
    idle(2, 1'b1);
    check_eq("after_trunc_checksum", frame_checksum, 32'd880);
    check_eq("after_trunc_count", 32'(frame_count), 32'd4);

    // Enable dropped mid-frame, pulses keep coming.
    line(H, 1'b0, 1'b0);
    line(H, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h5A5);
    frame(1'b0, 1'b0);
    idle(2, 1'b0);
    check_eq("reenable_checksum", frame_checksum, 32'd880);
    check_eq("reenable_count", 32'(frame_count), 32'd5);

    // Reset mid-frame.
    line(H, 1'b0, 1'b0);
    samples(3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF);
    @(posedge clk); #2;
    check_eq("rst_valid", 32'(pixel_valid), 32'd0);
    check_eq("rst_data", 32'(pixel_data), 32'd0);
    check_eq("rst_col_row", 32'({col, row}), 32'd0);
    check_eq("rst_checksum", frame_checksum, 32'd0);
    check_eq("rst_count", 32'(frame_count), 32'd0);
    check_eq("rst_flags", 32'({line_error, frame_error, frame_done}), 32'd0);

    // vsync fall coinciding with a sample.
    line(H, 1'b0, 1'b0);
    samples(2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h123);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h0);
    check_eq("vs_sample_ferr", 32'(frame_error), 32'd1);
    idle(2, 1'b1);

    // Short-line edge coinciding with clear.
    line(H, 1'b0, 1'b0);
    samples(4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0);
    check_eq("err_beats_clear", 32'(line_error), 32'd1);
    idle(2, 1'b0);

    @(posedge clk); #2;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
